// File: rtl/lc3b_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lc3b_types (package)
//  Description : Shared types for the LC-3b memory responder: data word,
//                byte-enable pair, responder FSM state encoding and a lane
//                merge helper used by the storage array.
//  Revision    : 1.0 - initial release
// ============================================================================
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_be;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } lc3b_memresp_state;

    // Width of the latency down-counter; LATENCY is limited to 1..255.
    localparam int c_cnt_w = 8;

    // Replace only the byte lanes selected by be; be[0] -> 7:0, be[1] -> 15:8.
    function automatic lc3b_word merge_lanes(input lc3b_word   old_word,
                                             input lc3b_word   new_word,
                                             input lc3b_mem_be be);
        lc3b_word merged;
        merged       = old_word;
        if (be[0]) merged[7:0]  = new_word[7:0];
        if (be[1]) merged[15:8] = new_word[15:8];
        return merged;
    endfunction

endpackage : lc3b_types
`default_nettype wire

// File: rtl/lc3b_mem_responder_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : mem_array
//  Description : 2**ADDR_BITS x 16 word storage with byte-lane write enables.
//                Synchronous write, combinational read, no reset (contents
//                survive reset by design).
//  Ports       : clk      - write clock
//                we       - write strobe for this edge
//                be       - byte lanes to update when we=1
//                wr_addr  - word write address
//                wdata    - write data
//                rd_addr  - word read address
//                rdata    - read data (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_array
    import lc3b_types::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  lc3b_mem_be           be,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  lc3b_word             wdata,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output lc3b_word             rdata
);

    localparam int c_depth = 2 ** ADDR_BITS;

    lc3b_word r_mem [0:c_depth-1];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[wr_addr] <= merge_lanes(r_mem[wr_addr], wdata, be);
        end
    end

    assign rdata = r_mem[rd_addr];

endmodule : mem_array
`default_nettype wire

// File: rtl/lc3b_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : lc3b_mem_responder
//  Description : Memory-side responder for the LC-3b MAR/MDR interface.
//                Accepts a held read/write request, answers with a one-cycle
//                mem_resp pulse LATENCY cycles after the request first went
//                high, and flags protocol violations on a sticky proto_err.
//  Ports       : clk             - system clock, rising edge
//                rst_n           - asynchronous active-low reset
//                mem_read        - read request, held until mem_resp
//                mem_write       - write request, held until mem_resp
//                mem_byte_enable - write lanes: [0]=7:0, [1]=15:8
//                mem_address     - byte address (bit 0 and high bits ignored)
//                mem_wdata       - write data
//                mem_resp        - one-cycle completion pulse
//                mem_rdata       - read data, valid in the mem_resp cycle
//                proto_err       - sticky protocol-error flag
//  Revision    : 1.0 - initial release
// ============================================================================
module lc3b_mem_responder
    import lc3b_types::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mem_read,
    input  logic       mem_write,
    input  logic [1:0] mem_byte_enable,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_wdata,
    output logic       mem_resp,
    output logic [15:0] mem_rdata,
    output logic       proto_err
);

    localparam logic [c_cnt_w-1:0] c_load = c_cnt_w'(LATENCY - 1);
    localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

    lc3b_memresp_state      r_state;
    logic [c_cnt_w-1:0]     r_count;
    logic [ADDR_BITS-1:0]   r_addr;
    lc3b_word               r_wdata;
    lc3b_mem_be             r_be;
    logic                   r_is_write;

    logic                   w_req;
    logic [ADDR_BITS-1:0]   w_live_addr;
    logic [ADDR_BITS-1:0]   w_rd_addr;
    logic                   w_array_we;
    lc3b_word               w_rd_data;
    logic                   w_unused_addr_bits;

    assign w_req       = mem_read | mem_write;
    assign w_live_addr = mem_address[ADDR_BITS:1];

    // Only the word index participates; the byte bit and the bits above the
    // array size alias onto the same words.
    assign w_unused_addr_bits = ^{mem_address[15:ADDR_BITS+1], mem_address[0]};

    // With LATENCY=1 the read data is sampled on the very edge that accepts
    // the request, before r_addr holds it, so the live address is used then.
    assign w_rd_addr  = (r_state == IDLE) ? w_live_addr : r_addr;

    // The array is written on the edge that ends the RESP cycle. Gating on
    // the (asynchronously reset) state guarantees no write after a reset.
    assign w_array_we = (r_state == RESP) && r_is_write;

    mem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_mem_array (
        .clk     (clk),
        .we      (w_array_we),
        .be      (r_be),
        .wr_addr (r_addr),
        .wdata   (r_wdata),
        .rd_addr (w_rd_addr),
        .rdata   (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_is_write <= 1'b0;
            mem_resp   <= 1'b0;
            mem_rdata  <= 16'h0000;
            proto_err  <= 1'b0;
        end else begin
            mem_resp <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_addr     <= w_live_addr;
                        r_wdata    <= mem_wdata;
                        r_be       <= mem_byte_enable;
                        // Simultaneous read+write resolves to a write.
                        r_is_write <= mem_write;
                        if (mem_read && mem_write) begin
                            proto_err <= 1'b1;
                        end
                        if (LATENCY == 1) begin
                            r_state  <= RESP;
                            mem_resp <= 1'b1;
                            if (!mem_write) begin
                                mem_rdata <= w_rd_data;
                            end
                        end else begin
                            r_state <= BUSY;
                            r_count <= c_load;
                        end
                    end
                end

                BUSY: begin
                    if (!w_req) begin
                        // Requester gave up mid-transaction: drop it silently.
                        r_state   <= IDLE;
                        proto_err <= 1'b1;
                    end else if (r_count == c_one) begin
                        r_state  <= RESP;
                        mem_resp <= 1'b1;
                        if (!r_is_write) begin
                            mem_rdata <= w_rd_data;
                        end
                    end else begin
                        r_count <= r_count - c_one;
                    end
                end

                RESP: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : lc3b_mem_responder
`default_nettype wire

// File: tb/tb_lc3b_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lc3b_mem_responder
//  Description : Directed self-checking bench for lc3b_mem_responder.
//                Three instances: LATENCY=4 (main), LATENCY=1 and LATENCY=7
//                (latency sweep only). Inputs driven and outputs sampled on
//                the falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lc3b_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        rd4, wr4, rd1, rd7;
    logic [1:0]  be;
    logic [15:0] addr, wdata;

    logic        resp4, resp1, resp7;
    logic [15:0] rdata4, rdata1, rdata7;
    logic        perr4, perr1, perr7;

    int errors = 0;
    int checks = 0;

    lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .mem_read(rd4), .mem_write(wr4),
        .mem_byte_enable(be), .mem_address(addr), .mem_wdata(wdata),
        .mem_resp(resp4), .mem_rdata(rdata4), .proto_err(perr4));

    lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .mem_read(rd1), .mem_write(1'b0),
        .mem_byte_enable(be), .mem_address(addr), .mem_wdata(wdata),
        .mem_resp(resp1), .mem_rdata(rdata1), .proto_err(perr1));

    lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(7)) u_dut7 (
        .clk(clk), .rst_n(rst_n), .mem_read(rd7), .mem_write(1'b0),
        .mem_byte_enable(be), .mem_address(addr), .mem_wdata(wdata),
        .mem_resp(resp7), .mem_rdata(rdata7), .proto_err(perr7));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic sel_resp(input int sel);
        return (sel == 0) ? resp4 : (sel == 1) ? resp1 : resp7;
    endfunction

    function automatic logic [15:0] sel_rdata(input int sel);
        return (sel == 0) ? rdata4 : (sel == 1) ? rdata1 : rdata7;
    endfunction

    // Drives one transaction to instance sel (0:L4, 1:L1, 2:L7), holds it
    // until mem_resp, scrambles addr/data after acceptance, and reports
    // latency in cycles (-1 if none within 20), pulse count and read data.
    task automatic run_txn(input int sel, input logic rd, input logic wr,
                           input logic [15:0] a, input logic [15:0] d,
                           input logic [1:0] b,
                           output int lat, output int pulses,
                           output logic [15:0] rdat);
        @(negedge clk);
        addr = a; wdata = d; be = b;
        case (sel)
            0:       begin rd4 = rd; wr4 = wr; end
            1:       rd1 = rd;
            default: rd7 = rd;
        endcase
        lat = -1; pulses = 0; rdat = 16'hxxxx;
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            @(posedge clk); @(negedge clk);
            if (n == 1) begin
                addr = ~a; wdata = ~d; be = ~b;
            end
            if (sel_resp(sel)) begin
                lat = n; pulses = 1; rdat = sel_rdata(sel);
            end
        end
        rd4 = 1'b0; wr4 = 1'b0; rd1 = 1'b0; rd7 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); @(negedge clk);
            if (sel_resp(sel)) pulses++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; rd4 = 0; wr4 = 0; rd1 = 0; rd7 = 0;
        be = 2'b00; addr = 16'h0; wdata = 16'h0;
        #3 rst_n = 1'b0;
        #1;
        checks++; if (resp4 !== 1'b0)      begin errors++; $display("FAIL reset_resp got=%b want=0", resp4); end
        checks++; if (rdata4 !== 16'h0000) begin errors++; $display("FAIL reset_rdata got=%h want=0000", rdata4); end
        checks++; if (perr4 !== 1'b0)      begin errors++; $display("FAIL reset_perr got=%b want=0", perr4); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        int lat, pulses; logic [15:0] rd;
        run_txn(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, lat, pulses, rd);
        checks++; if (lat !== 4)    begin errors++; $display("FAIL wr_latency got=%0d want=4", lat); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL wr_pulses got=%0d want=1", pulses); end
        run_txn(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, lat, pulses, rd);
        checks++; if (lat !== 4)       begin errors++; $display("FAIL rd_latency got=%0d want=4", lat); end
        checks++; if (pulses !== 1)    begin errors++; $display("FAIL rd_pulses got=%0d want=1", pulses); end
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL rd_data got=%h want=BEEF", rd); end
        checks++; if (rdata4 !== 16'hBEEF) begin errors++; $display("FAIL rd_data_hold got=%h want=BEEF", rdata4); end
        checks++; if (perr4 !== 1'b0)  begin errors++; $display("FAIL wr_rd_perr got=%b want=0", perr4); end
    endtask

    task automatic test_byte_lanes();
        int lat, pulses; logic [15:0] rd;
        run_txn(0, 1'b0, 1'b1, 16'h0020, 16'h1234, 2'b11, lat, pulses, rd);
        run_txn(0, 1'b0, 1'b1, 16'h0020, 16'hAB00, 2'b10, lat, pulses, rd);
        run_txn(0, 1'b0, 1'b1, 16'h0020, 16'h00CD, 2'b01, lat, pulses, rd);
        run_txn(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, lat, pulses, rd);
        checks++; if (rd !== 16'hABCD) begin errors++; $display("FAIL lanes_merge got=%h want=ABCD", rd); end
        run_txn(0, 1'b0, 1'b1, 16'h0020, 16'hFFFF, 2'b00, lat, pulses, rd);
        checks++; if (lat !== 4)   begin errors++; $display("FAIL be00_resp_latency got=%0d want=4", lat); end
        checks++; if (rdata4 !== 16'hABCD) begin errors++; $display("FAIL write_keeps_rdata got=%h want=ABCD", rdata4); end
        run_txn(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, lat, pulses, rd);
        checks++; if (rd !== 16'hABCD) begin errors++; $display("FAIL be00_no_write got=%h want=ABCD", rd); end
    endtask

    task automatic test_wrap();
        int lat, pulses; logic [15:0] rd;
        run_txn(0, 1'b0, 1'b1, 16'h0202, 16'h7777, 2'b11, lat, pulses, rd);
        run_txn(0, 1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00, lat, pulses, rd);
        checks++; if (rd !== 16'h7777) begin errors++; $display("FAIL wrap_alias got=%h want=7777", rd); end
        run_txn(0, 1'b1, 1'b0, 16'h0003, 16'h0000, 2'b00, lat, pulses, rd);
        checks++; if (rd !== 16'h7777) begin errors++; $display("FAIL wrap_odd got=%h want=7777", rd); end
    endtask

    task automatic test_abort();
        int lat, pulses, seen; logic [15:0] rd;
        run_txn(0, 1'b0, 1'b1, 16'h0030, 16'h0000, 2'b11, lat, pulses, rd);
        checks++; if (perr4 !== 1'b0) begin errors++; $display("FAIL abort_pre_perr got=%b want=0", perr4); end
        seen = 0;
        @(negedge clk);
        addr = 16'h0030; wdata = 16'h5555; be = 2'b11; wr4 = 1'b1;
        @(posedge clk); @(negedge clk); if (resp4) seen++;
        @(posedge clk); @(negedge clk); if (resp4) seen++;
        wr4 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); @(negedge clk);
            if (resp4) seen++;
        end
        checks++; if (seen !== 0)     begin errors++; $display("FAIL abort_no_resp got=%0d want=0", seen); end
        checks++; if (perr4 !== 1'b1) begin errors++; $display("FAIL abort_perr got=%b want=1", perr4); end
        run_txn(0, 1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, lat, pulses, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL abort_no_write got=%h want=0000", rd); end
    endtask

    task automatic test_reset_mid();
        int lat, pulses; logic [15:0] rd;
        run_txn(0, 1'b0, 1'b1, 16'h0050, 16'h9999, 2'b11, lat, pulses, rd);
        run_txn(0, 1'b1, 1'b0, 16'h0050, 16'h0000, 2'b00, lat, pulses, rd);
        checks++; if (rd !== 16'h9999) begin errors++; $display("FAIL rstmid_preload got=%h want=9999", rd); end
        @(negedge clk);
        addr = 16'h0050; wdata = 16'h1111; be = 2'b11; wr4 = 1'b1;
        @(posedge clk); @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (resp4 !== 1'b0)      begin errors++; $display("FAIL rstmid_resp got=%b want=0", resp4); end
        checks++; if (rdata4 !== 16'h0000) begin errors++; $display("FAIL rstmid_rdata got=%h want=0000", rdata4); end
        checks++; if (perr4 !== 1'b0)      begin errors++; $display("FAIL rstmid_perr got=%b want=0", perr4); end
        @(negedge clk) wr4 = 1'b0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        run_txn(0, 1'b1, 1'b0, 16'h0050, 16'h0000, 2'b00, lat, pulses, rd);
        checks++; if (lat !== 4)       begin errors++; $display("FAIL rstmid_post_latency got=%0d want=4", lat); end
        checks++; if (rd !== 16'h9999) begin errors++; $display("FAIL rstmid_word_kept got=%h want=9999", rd); end
    endtask

    task automatic test_rw_conflict();
        int lat, pulses; logic [15:0] rd;
        run_txn(0, 1'b0, 1'b1, 16'h0040, 16'h0000, 2'b11, lat, pulses, rd);
        checks++; if (perr4 !== 1'b0) begin errors++; $display("FAIL rw_pre_perr got=%b want=0", perr4); end
        run_txn(0, 1'b1, 1'b1, 16'h0040, 16'h4242, 2'b11, lat, pulses, rd);
        checks++; if (lat !== 4)       begin errors++; $display("FAIL rw_latency got=%0d want=4", lat); end
        checks++; if (perr4 !== 1'b1)  begin errors++; $display("FAIL rw_perr got=%b want=1", perr4); end
        checks++; if (rdata4 !== 16'h9999) begin errors++; $display("FAIL rw_rdata_kept got=%h want=9999", rdata4); end
        run_txn(0, 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, lat, pulses, rd);
        checks++; if (rd !== 16'h4242) begin errors++; $display("FAIL rw_as_write got=%h want=4242", rd); end
    endtask

    task automatic test_latency_sweep();
        int lat, pulses; logic [15:0] rd;
        run_txn(1, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, lat, pulses, rd);
        checks++; if (lat !== 1)    begin errors++; $display("FAIL lat1_latency got=%0d want=1", lat); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL lat1_pulses got=%0d want=1", pulses); end
        run_txn(2, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, lat, pulses, rd);
        checks++; if (lat !== 7)    begin errors++; $display("FAIL lat7_latency got=%0d want=7", lat); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL lat7_pulses got=%0d want=1", pulses); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_wrap();
        test_abort();
        test_reset_mid();
        test_rw_conflict();
        test_latency_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_lc3b_mem_responder
`default_nettype wire

// File: doc/lc3b_mem_responder.md
Name: lc3b_mem_responder

Overview:
- Memory-side responder for the LC-3b core memory interface.
- Services the read/write requests that the datapath/control pair issues through the MAR/MDR.
- Holds a word-addressed storage array and returns a single-cycle mem_resp pulse after a programmable latency.
- Serves as the synthesizable/simulatable memory model for the core bench and as the future base for a cache-to-memory stub.

Parameters:
- ADDR_BITS, 8, number of word-address bits; array holds 2**ADDR_BITS 16-bit words, indexed by mem_address[ADDR_BITS:1].
- LATENCY, 4, cycles from first request cycle to mem_resp; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mem_read  input  1  read request; held high until mem_resp.
- mem_write  input  1  write request; held high until mem_resp.
- mem_byte_enable  input  2  write lane enables: [0]=bits 7:0, [1]=bits 15:8.
- mem_address  input  16  byte address; bit 0 ignored, bits above ADDR_BITS ignored (wrap).
- mem_wdata  input  16  write data.
- mem_resp  output  1  one-cycle completion pulse.
- mem_rdata  output  16  read data, valid in the mem_resp cycle.
- proto_err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (rst_n=0, async): FSM to IDLE, counter 0, mem_resp=0, mem_rdata=16'h0000, proto_err=0. Array contents are not reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE -> BUSY (or RESP if LATENCY=1) on a rising edge with mem_read|mem_write=1.
  - The edge captures address, wdata, byte enables, and op.
  - Counter loads LATENCY-1.
- BUSY decrements each cycle; at count 1 it goes to RESP.
- RESP lasts one cycle with mem_resp=1, then returns to IDLE.
- Timing: request first high in cycle T gives mem_resp=1 in cycle T+LATENCY, exactly one cycle wide. The core drops its request on the edge ending T+LATENCY.
- A request still high in the cycle after RESP is a new transaction. It is accepted in IDLE; at least one idle cycle separates back-to-back responses.
- Read:
  - mem_rdata is driven from the array word at the captured address in the RESP cycle.
  - It is registered and holds its value until the next read response.
  - Writes do not change mem_rdata.
- Write:
  - The array is updated on the edge ending the RESP cycle, per lane enable.
  - be=2'b00 still responds but modifies nothing.
- Captured values are used, not live inputs. Changes to address/data after acceptance are ignored.
- Abort:
  - If mem_read and mem_write both drop during BUSY (cycles T+1..T+LATENCY-1), the FSM returns to IDLE.
  - No mem_resp is issued, no array write happens, and mem_rdata is unchanged.
  - proto_err is set.
- mem_read and mem_write both high at acceptance: treated as a write, and proto_err is set.
- proto_err clears only on reset.
- Address wrap: mem_address[ADDR_BITS:1] indexes the array. For example, with ADDR_BITS=8, 16'h0202 and 16'h0002 hit the same word.
- Reset mid-transaction: the transaction is dropped with no write and no resp. After rst_n deasserts, the responder is in IDLE.

Decomposition:
- lc3b_types package:
  - uses existing lc3b_word.
  - adds typedef lc3b_mem_be (logic [1:0]).
  - adds enum lc3b_memresp_state {IDLE, BUSY, RESP}.
- Sub-module mem_array:
  - 2**ADDR_BITS x 16 storage.
  - byte-lane write enables, synchronous write, combinational read.
  - no reset.
- The FSM/counter stays in lc3b_mem_responder.

Test Plan (LATENCY=4, ADDR_BITS=8 unless stated):
- Write/read-back: write 16'hBEEF to 16'h0010 with be=2'b11, then read 16'h0010 -> mem_resp exactly at T+4 for each, mem_rdata=16'hBEEF, proto_err=0.
- Byte lanes: preload 16'h1234 at 16'h0020, write 16'hAB00 with be=2'b10, then write 16'h00CD with be=2'b01 -> read returns 16'hABCD; be=2'b00 write of 16'hFFFF -> read still 16'hABCD.
- Latency sweep with LATENCY=1, then 7: single read -> mem_resp at T+1 / T+7, one cycle wide, no second pulse while the request drops.
- Abort: drop mem_write at T+2 of a write of 16'h5555 to 16'h0030 (prior value 16'h0000) -> no mem_resp, proto_err=1, later read of 16'h0030 returns 16'h0000.
- Wrap/alias: write 16'h7777 to 16'h0202 -> read 16'h0002 returns 16'h7777; read 16'h0003 (odd) also returns 16'h7777.
- Async reset mid-BUSY: assert rst_n=0 at T+2 of a write, between clock edges -> mem_resp=0 and mem_rdata=0 immediately, proto_err=0, target word unchanged; a new read after release completes at T'+4.
